platform_collision: RTL

PLATFORM_COLLISION -- requirements
Module: platform_collision

---
 rtl/platform_collision.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/platform_collision.sv
// platform_collision
//
// Once per frame, finds the platform the doodle lands on. A frame_tick
// captures the doodle position and direction, then one platform slot is
// checked per clock, lowest index first. The first hit ends the scan and
// produces a one-cycle land pulse, with the slot index and its top y held
// on land_index / land_y until the next landing. A landing above
// SCROLL_LINE raises move_collision, which the platform stage consumes on
// its next frame_tick.
//
// State table:
//   state | meaning
//   IDLE  | waiting for frame_tick; the previous land result is held
//   SCAN  | checking slot idx against the captured doodle, one slot per clock
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   frame_tick           one-cycle pulse per frame; starts (or restarts) a scan
//   platforms            per slot: [0] = top y, [1] = left x (signed 11 bit)
//   platform_activation  per-slot enable
//   doodle_x, doodle_y   doodle top-left corner (unsigned)
//   doodle_falling       doodle is moving downward
//   land                 one-cycle landing pulse
//   land_index, land_y   slot and top y of the most recent landing
//   move_collision       scroll request, held until the cycle after the next tick
//   busy                 scan in progress
//   overrun              sticky: a frame_tick arrived while a scan was running

module platform_collision #(
    parameter int N_PLAT      = 90,
    parameter int PLAT_W      = 100,
    parameter int DOODLE_W    = 80,
    parameter int DOODLE_H    = 80,
    parameter int FOOT_TOL    = 12,
    parameter int SCROLL_LINE = 400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic signed [10:0] platforms [N_PLAT][2],
    input  logic [N_PLAT-1:0]  platform_activation,
    input  logic [10:0]        doodle_x,
    input  logic [9:0]         doodle_y,
    input  logic               doodle_falling,
    output logic               land,
    output logic [6:0]         land_index,
    output logic signed [10:0] land_y,
    output logic               move_collision,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // All geometry is compared in 12-bit signed arithmetic.
    localparam logic signed [11:0] DOODLE_H_S   = 12'(DOODLE_H);
    localparam logic signed [11:0] DOODLE_W_M1  = 12'(DOODLE_W - 1);
    localparam logic signed [11:0] PLAT_W_M1    = 12'(PLAT_W - 1);
    localparam logic signed [11:0] FOOT_TOL_M1  = 12'(FOOT_TOL - 1);
    localparam logic signed [11:0] SCROLL_S     = 12'(SCROLL_LINE);
    localparam logic [6:0]         LAST_IDX     = 7'(N_PLAT - 1);

    state_t     state_q, state_d;
    logic [6:0] idx_q, idx_d;

    logic [10:0] dx_q;
    logic [9:0]  dy_q;
    logic        fall_q;

    logic signed [10:0] cur_y, cur_x;
    logic signed [11:0] py, px, dx_s, dy_s, feet;
    logic               hit, land_fire, last_slot;

    assign busy = (state_q == SCAN);

    // Live platform table, sampled for the slot under test this cycle.
    assign cur_y = platforms[idx_q][0];
    assign cur_x = platforms[idx_q][1];

    assign py   = {cur_y[10], cur_y};
    assign px   = {cur_x[10], cur_x};
    assign dx_s = {1'b0, dx_q};
    assign dy_s = {2'b00, dy_q};
    assign feet = dy_s + DOODLE_H_S;

    assign hit = busy
               && platform_activation[idx_q]
               && fall_q
               && (feet >= py)
               && (feet <= py + FOOT_TOL_M1)
               && (dx_s + DOODLE_W_M1 >= px)
               && (dx_s <= px + PLAT_W_M1);

    // A tick in the same cycle as a hit throws the hit away: the new frame
    // has already moved the platforms.
    assign land_fire = hit && !frame_tick;
    assign last_slot = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (frame_tick) begin
            state_d = SCAN;
            idx_d   = '0;
        end else if (state_q == SCAN) begin
            if (hit || last_slot) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            fall_q         <= 1'b0;
            land           <= 1'b0;
            land_index     <= '0;
            land_y         <= '0;
            move_collision <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;

            if (frame_tick) begin
                dx_q   <= doodle_x;
                dy_q   <= doodle_y;
                fall_q <= doodle_falling;
            end

            land <= land_fire;
            if (land_fire) begin
                land_index <= idx_q;
                land_y     <= cur_y;
            end

            // Held across the next tick so the platform stage sees it on
            // the tick cycle itself.
            if (land_fire && (py < SCROLL_S)) begin
                move_collision <= 1'b1;
            end else if (frame_tick) begin
                move_collision <= 1'b0;
            end

            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
